// File: rtl/display_mux_bcd.sv
// Multi-digit 7-segment driver: sequential binary-to-BCD conversion feeding a
// time-multiplexed, ghost-free segment/anode scan with blanking, dp and overflow.
module display_mux_bcd #(
  parameter int N_DIGITS      = 4,
  parameter int BIN_W         = 14,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [BIN_W-1:0]    valor,
  input  logic [N_DIGITS-1:0] dp_mask,
  output logic                busy,
  output logic                overflow,
  output logic [7:0]          salida_display,
  output logic [N_DIGITS-1:0] anodo
);

  // Decimal digits needed for 2^w-1; w is at most 27 so an int holds it.
  function automatic int bcd_digits(input int w);
    int m;
    int n;
    m = (1 << w) - 1;
    n = 1;
    for (int i = 0; i < 10; i++) begin
      if (m >= 10) begin
        m = m / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  localparam int NB  = bcd_digits(BIN_W);
  localparam int NBP = (NB > N_DIGITS) ? NB : N_DIGITS;
  localparam int AW  = 4 * NBP;
  localparam int DW  = 4 * N_DIGITS;
  localparam int CW  = $clog2(BIN_W + 1);
  localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW  = $clog2(REFRESH_DIV);

  localparam logic [7:0] SEG_BLANK = 8'b11111111;
  localparam logic [7:0] SEG_DASH  = 8'b11111101;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t            state;
  logic [BIN_W-1:0]  sh;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     acc_adj;
  logic              acc_ovf;
  logic [CW-1:0]     cnt;
  logic [DW-1:0]     disp;

  logic [PW-1:0]     presc;
  logic              tc;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_n;
  logic [3:0]        nib;
  logic              dp_on;
  logic              hi_nz;
  logic [7:0]        seg_n;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'b00000011;
      4'd1:    s = 8'b10011111;
      4'd2:    s = 8'b00100101;
      4'd3:    s = 8'b00001101;
      4'd4:    s = 8'b10011001;
      4'd5:    s = 8'b01001001;
      4'd6:    s = 8'b01000001;
      4'd7:    s = 8'b00011111;
      4'd8:    s = 8'b00000001;
      4'd9:    s = 8'b00011001;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < NBP; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Any nonzero nibble beyond the displayable digits means the value cannot be shown.
  always_comb begin
    acc_ovf = 1'b0;
    for (int i = 0; i < NBP; i++) begin
      if (i >= N_DIGITS && acc[4*i +: 4] != 4'd0) acc_ovf = 1'b1;
    end
  end

  // Shift-add-3 converter; disp only changes in COMMIT so the scan never sees partial digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sh       <= '0;
      acc      <= '0;
      cnt      <= '0;
      disp     <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            sh    <= valor;
            acc   <= '0;
            cnt   <= CW'(BIN_W);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= {acc_adj[AW-2:0], sh[BIN_W-1]};
          sh  <= sh << 1;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= COMMIT;
        end
        COMMIT: begin
          disp     <= acc[DW-1:0];
          overflow <= acc_ovf;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign tc = (presc == PW'(REFRESH_DIV - 1));

  always_comb begin
    idx_n = idx;
    if (tc) idx_n = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
  end

  // Segments are computed for the digit the anodes will select after this edge.
  always_comb begin
    nib   = 4'd0;
    dp_on = 1'b0;
    hi_nz = 1'b0;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (j == int'(idx_n)) begin
        nib   = disp[4*j +: 4];
        dp_on = dp_mask[j];
      end
      if (j >= int'(idx_n) && disp[4*j +: 4] != 4'd0) hi_nz = 1'b1;
    end
    if (overflow)
      seg_n = SEG_DASH;
    else if (BLANK_LEADING != 0 && idx_n != '0 && !hi_nz)
      seg_n = SEG_BLANK;
    else
      seg_n = seg_code(nib);
    if (dp_on) seg_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc          <= '0;
      idx            <= '0;
      anodo          <= ~(N_DIGITS'(1));
      salida_display <= 8'b00000011;
    end else begin
      presc          <= tc ? '0 : presc + 1'b1;
      idx            <= idx_n;
      anodo          <= ~(N_DIGITS'(1) << idx_n);
      salida_display <= seg_n;
    end
  end

endmodule

// File: doc/display_mux_bcd.md
Name: display_mux_bcd

Overview:
- Parametrised multi-digit 7-segment driver: takes an unsigned binary value, converts it to BCD sequentially (shift-add-3, one bit per clock) and time-multiplexes the digits onto one shared segment bus with per-digit anode enables.
- Adds three features the single-digit combinational decoder lacks: leading-zero blanking, per-digit decimal point and an overflow indication.
- Sits between the datapath result register and the board display pins.

Parameters:
- N_DIGITS, 4, number of displayed digits (1..8).
- BIN_W, 14, width of the binary input value (1..27).
- REFRESH_DIV, 50000, clock cycles each digit stays enabled (>=2).
- BLANK_LEADING, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- load, input, 1, one-cycle strobe: capture valor and start conversion.
- valor, input, BIN_W, unsigned binary value to display.
- dp_mask, input, N_DIGITS, bit i=1 lights the decimal point of digit i (digit 0 = least significant); sampled live.
- busy, output, 1, conversion in progress.
- overflow, output, 1, latched value exceeds 10^N_DIGITS-1.
- salida_display, output, 8, segments, active low: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- anodo, output, N_DIGITS, digit enables, active low, one-hot.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n is asynchronous and active-low; all flops clear immediately on assertion and release synchronously with clk.
- Reset values:
  - busy=0, overflow=0.
  - Displayed BCD register = 0, scan index = 0, prescaler = 0.
  - anodo = all ones except bit0 = 0.
  - salida_display = 8'b00000011 ("0" on digit 0).
- Segment codes, dp off (bit0 = 1):
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001
  - 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00011001
  - blank=11111111, dash=11111101.
- Conversion FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: if load=1, capture valor into the shift register, clear the BCD accumulator, load the bit counter with BIN_W, go to SHIFT.
  - SHIFT: one bit per cycle. Add 3 to every BCD nibble >=5, then shift left by 1, bringing in the MSB of the shift register. Decrement the counter; when it reaches 0, go to COMMIT.
  - COMMIT: copy the accumulator into the displayed register in one cycle (atomic update, no partially converted digits ever shown). Set overflow if any BCD nibble above digit N_DIGITS-1 is nonzero. Go to IDLE.
  - The BCD accumulator carries enough nibbles to represent 2^BIN_W-1.
- busy: high in SHIFT and COMMIT. With load at edge T, busy rises after edge T, stays high for BIN_W+1 cycles, and the new value is visible from edge T+BIN_W+1.
- load while busy=1 is ignored; no queueing.
- load and reset together: reset wins.
- Reset mid-conversion: aborts the conversion, returns to IDLE, display reverts to the reset state.
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1. On terminal count it wraps and the scan index advances, with N_DIGITS-1 wrapping to 0.
  - anodo is registered, one-hot active low at index position.
  - salida_display is registered and updates on the same edge as anodo, so no ghosting cycle.
  - The scan runs continuously, independent of busy.
- Digit selection, in priority order:
  1. overflow=1: every digit shows dash; dp still applies.
  2. BLANK_LEADING=1 and digit i>0 and digits i..N_DIGITS-1 are all zero: blank. A dp in a blanked digit still lights.
  3. Otherwise: the decoded BCD nibble.
  - Digit 0 is never blanked.
  - dp_mask[i]=1 clears bit0 of digit i.

Test Plan:
- Reset then release, run 4*REFRESH_DIV cycles (REFRESH_DIV=4 in bench) -> anodo cycles 1110, 1101, 1011, 0111, 1110; segments 00000011 on digit 0 and 11111111 on digits 1-3; busy=0, overflow=0.
- load with valor=1234 -> busy high exactly 15 cycles; afterwards scan shows digit0=10011001 (4), digit1=00001101 (3), digit2=00100101 (2), digit3=10011111 (1).
- load with valor=7, BLANK_LEADING=1 -> digit0=00011111, digits 1-3 blank. Repeat with BLANK_LEADING=0 -> digits 1-3 show 00000011.
- load with valor=10000 -> overflow=1, all digits 11111101. Then load 9999 -> overflow=0, all digits 00011001.
- Pulse load with 1234 mid-conversion of 5678 -> second load ignored; result 5678. Assert rst_n=0 mid-conversion -> outputs return to reset values asynchronously, busy=0 immediately.
- dp_mask=0010 with value 42 -> digit1 = 10011000, digit0 = 00100101, digits 2-3 = 11111111.
